// File: rtl/matrix_scan_controller.sv
// Column-multiplexed scan driver for a 5-column mirrored LED matrix.
// Images are double-buffered and swap only at a frame wrap or while the display is off.
module matrix_scan_controller #(
   parameter int DWELL_CYCLES = 1000,
   parameter int BLANK_CYCLES = 50,
   parameter int BLINK_FRAMES = 50
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [20:0] image_in,
   input  logic        image_valid,
   output logic        image_ready,
   input  logic        blink,
   output logic [4:0]  col,
   output logic [6:0]  row,
   output logic        frame_done
);

   localparam int DW = $clog2(DWELL_CYCLES);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [DW-1:0] BLANK_LIM  = DW'(BLANK_CYCLES);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} scan_state_e;

   scan_state_e   state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [2:0]    col_idx_q, col_idx_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          hidden_q, hidden_d;
   logic [20:0]   active_q, active_d;
   logic [20:0]   pending_q, pending_d;
   logic          pending_full_q, pending_full_d;
   logic [4:0]    col_q, col_d;
   logic [6:0]    row_q, row_d;
   logic          frame_done_q, frame_done_d;
   logic          wrap;

   // Columns 3 and 4 mirror columns 1 and 0.
   function automatic logic [6:0] col_rows(input logic [20:0] img, input logic [2:0] idx);
      case (idx)
         3'd1, 3'd3: col_rows = img[13:7];
         3'd2:       col_rows = img[20:14];
         default:    col_rows = img[6:0];
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= S_OFF;
         dwell_q        <= '0;
         col_idx_q      <= '0;
         frame_cnt_q    <= '0;
         hidden_q       <= 1'b0;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         col_q          <= '0;
         row_q          <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         dwell_q        <= dwell_d;
         col_idx_q      <= col_idx_d;
         frame_cnt_q    <= frame_cnt_d;
         hidden_q       <= hidden_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         col_q          <= col_d;
         row_q          <= row_d;
         frame_done_q   <= frame_done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      dwell_d        = dwell_q;
      col_idx_d      = col_idx_q;
      frame_cnt_d    = frame_cnt_q;
      hidden_d       = hidden_q;
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      col_d          = '0;
      row_d          = '0;
      wrap           = 1'b0;

      if (!enable || state_q == S_OFF) begin
         dwell_d   = '0;
         col_idx_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
         dwell_d = '0;
         if (col_idx_q == 3'd4) begin
            col_idx_d = '0;
            wrap      = 1'b1;
         end else begin
            col_idx_d = col_idx_q + 3'd1;
         end
      end else begin
         dwell_d = dwell_q + 1'b1;
      end

      if (!enable)
         state_d = S_OFF;
      else if (dwell_d < BLANK_LIM)
         state_d = S_BLANK;
      else
         state_d = S_DRIVE;

      if (!blink) begin
         frame_cnt_d = '0;
         hidden_d    = 1'b0;
      end else if (wrap) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            hidden_d    = !hidden_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end

      // Swap and accept are exclusive: a swap needs a full buffer, an accept an empty one.
      if (pending_full_q && (wrap || !enable)) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
      end
      if (image_valid && !pending_full_q) begin
         pending_d      = image_in;
         pending_full_d = 1'b1;
      end

      frame_done_d = wrap;
      if (state_d != S_OFF) begin
         col_d = 5'b00001 << col_idx_d;
         if (state_d == S_DRIVE && !hidden_d)
            row_d = col_rows(active_d, col_idx_d);
      end
   end

   assign col         = col_q;
   assign row         = row_q;
   assign frame_done  = frame_done_q;
   assign image_ready = !pending_full_q;

endmodule
